rate_count_scheduler: RTL

//  Run/pause/clear controller that schedules count steps at a selectable rate. Replaces a free-running divided clock

---
 rtl/rate_count_scheduler_if.sv | 23 ++
 rtl/rate_count_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/rate_count_scheduler_if.sv
// Key-side controls and display-side count outputs of the rate count scheduler.
// master drives the keys and reads the count; slave is the scheduler itself.
interface rate_count_scheduler_if;
    logic       start_btn;
    logic       stop_btn;
    logic       clear;
    logic       fast_sel;
    logic       tick;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;

    modport master (
        output start_btn, stop_btn, clear, fast_sel,
        input  tick, ones, tens, running, wrap
    );

    modport slave (
        input  start_btn, stop_btn, clear, fast_sel,
        output tick, ones, tens, running, wrap
    );
endinterface

// File: rtl/rate_count_scheduler.sv
// Run/pause/clear scheduler stepping a two-digit BCD count (01..99, wraps to 01)
// at a selectable rate, using a single-clock step enable instead of a divided clock.
module rate_count_scheduler #(
    parameter int unsigned DIV_FAST = 1,
    parameter int unsigned DIV_SLOW = 1_000_000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    rate_count_scheduler_if.slave bus
);
    // state | meaning
    // IDLE  | stopped, count at 01, prescaler held at 0
    // RUN   | prescaler counting, a step fires every DIV cycles
    // PAUSE | prescaler and digits frozen; resume continues the partial period
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(DIV_FAST - 1);
    localparam logic [CNT_W-1:0] LIM_SLOW = CNT_W'(DIV_SLOW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       ones_q, ones_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             start_prev, stop_prev;
    logic             start_rise, stop_rise;
    logic [CNT_W-1:0] lim;

    assign start_rise = bus.start_btn & ~start_prev;
    assign stop_rise  = bus.stop_btn & ~stop_prev;
    assign lim        = bus.fast_sel ? LIM_FAST : LIM_SLOW;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd1;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
            // Held high so a key pressed through reset does not count as an edge.
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
            start_prev <= bus.start_btn;
            stop_prev  <= bus.stop_btn;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd1;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start_rise && !stop_rise) state_d = RUN;
                end
                RUN: begin
                    // >= rather than == so a rate increase mid-period fires at once.
                    if (presc_q >= lim) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (tens_q == 4'd9 && ones_q == 4'd9) begin
                            tens_d = 4'd0;
                            ones_d = 4'd1;
                            wrap_d = 1'b1;
                        end else if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + CNT_W'(1);
                    end
                    if (stop_rise) state_d = PAUSE;
                end
                PAUSE: begin
                    if (start_rise && !stop_rise) state_d = RUN;
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.tens    = tens_q;
    assign bus.ones    = ones_q;
    assign bus.running = (state_q == RUN);
endmodule
